// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_pkg                                                               |
// | Shared constants, fetch-state encoding and PC helpers for the pipeline.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pipeline_pkg;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] i_pc);
        return i_pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] i_addr);
        return i_addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_id_reg                                                                  |
// | IF/ID pipeline register: bubble insert beats load, otherwise hold.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_next,
    output logic [31:0] o_instr,
    output logic [31:0] o_next,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_next;
    logic        r_valid;

    // A bubble keeps Next_Address so ID still sees the last real PC+4.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr <= NOP_INSTR;
            r_next  <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_next  <= i_next;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_next  = r_next;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage                                                                |
// | IF stage: PC, req/valid instruction fetch, one-entry stall buffer, IF/ID.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        freeze,
    input  logic        PCSrc,
    input  logic [31:0] Branch_Address,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Instruction,
    output logic [31:0] Next_Address,
    output logic        IF_valid
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_drop_addr;
    logic [31:0]  w_drop_addr_nxt;
    logic [31:0]  r_buf_instr;
    logic [31:0]  w_buf_instr_nxt;
    logic [31:0]  r_buf_next;
    logic [31:0]  w_buf_next_nxt;
    logic [31:0]  w_pc_inc;
    logic [31:0]  w_ld_instr;
    logic [31:0]  w_ld_next;
    logic         w_done;
    logic         w_stall;
    logic         w_load;
    logic         w_bubble;

    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign w_done    = imem_req & imem_valid;
    assign w_stall   = ~PCWrite | freeze;
    assign w_pc_inc  = pc_inc(r_pc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= word_align(RESET_PC);
            r_drop_addr <= 32'd0;
            r_buf_instr <= NOP_INSTR;
            r_buf_next  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_next  <= w_buf_next_nxt;
        end
    end

    // The stall buffer is occupied exactly while in ST_HOLD, so no separate
    // occupancy flag is kept; leaving HOLD by any path empties it.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_next_nxt  = r_buf_next;
        w_load          = 1'b0;
        w_bubble        = 1'b0;
        w_ld_instr      = imem_rdata;
        w_ld_next       = w_pc_inc;

        if (PCSrc) begin
            w_pc_nxt = word_align(Branch_Address);
            w_bubble = 1'b1;
            if (r_state == ST_FETCH && !w_done) begin
                w_state_nxt     = ST_DROP;
                w_drop_addr_nxt = r_pc;
            end else if (r_state == ST_DROP && !w_done) begin
                w_state_nxt = ST_DROP;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end else begin
            w_bubble = flush;
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_done) begin
                        // A flushed completion is consumed even under stall.
                        if (flush || !w_stall) begin
                            w_pc_nxt = w_pc_inc;
                            w_load   = 1'b1;
                        end else begin
                            w_buf_instr_nxt = imem_rdata;
                            w_buf_next_nxt  = w_pc_inc;
                            w_state_nxt     = ST_HOLD;
                        end
                    end else if (!w_stall) begin
                        w_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush || !w_stall) begin
                        w_ld_instr  = r_buf_instr;
                        w_ld_next   = r_buf_next;
                        w_load      = 1'b1;
                        w_pc_nxt    = r_buf_next;
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    w_bubble = 1'b1;
                    if (w_done) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (w_ld_instr),
        .i_next   (w_ld_next),
        .o_instr  (Instruction),
        .o_next   (Next_Address),
        .o_valid  (IF_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage                                                             |
// | Cycle table plus scoreboarded fetch/delivery sequences for fetch_stage.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWrite = 1'b1;
    logic        freeze = 1'b0;
    logic        PCSrc = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Branch_Address = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] Instruction;
    logic [31:0] Next_Address;
    logic        IF_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .freeze         (freeze),
        .PCSrc          (PCSrc),
        .Branch_Address (Branch_Address),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_valid     (imem_valid),
        .Instruction    (Instruction),
        .Next_Address   (Next_Address),
        .IF_valid       (IF_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C00_5A5A ^ (a * 32'd7);
    endfunction

    // Instruction memory with a programmable number of wait cycles.
    int waits = 0;
    int mem_cnt = 0;
    assign imem_valid = imem_req && (mem_cnt >= waits);
    assign imem_rdata = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (!rst || !imem_req || imem_valid) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    // Scoreboard: expected completion addresses and delivered-instruction addresses.
    logic [31:0] exp_addr[$];
    logic [31:0] exp_deliv[$];
    bit   sb_en = 0;
    bit   bub_chk = 0;
    bit   first_deliv = 1;
    int   bub_cnt = 0;
    int   len_cnt = 0;
    bit   p_pend = 0;
    bit   p_rst = 0;
    bit   last_stall = 0;
    logic [31:0] p_addr = 32'd0;

    always @(negedge clk) begin
        logic [31:0] a;
        if (p_pend && p_rst) begin
            checks++;
            if (!imem_req || imem_addr !== p_addr) begin
                errors++;
                $display("FAIL addr_stable: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, p_addr);
            end
        end
        p_pend = imem_req && !imem_valid;
        p_rst  = rst;
        p_addr = imem_addr;

        if (sb_en && imem_req && imem_valid) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL fetch_addr: unexpected completion at %h", imem_addr);
            end else begin
                a = exp_addr.pop_front();
                if (imem_addr !== a) begin
                    errors++;
                    $display("FAIL fetch_addr: got %h, required %h", imem_addr, a);
                end
            end
            checks++;
            if (len_cnt != waits) begin
                errors++;
                $display("FAIL req_len: waited %0d cycles, required %0d", len_cnt, waits);
            end
        end
        len_cnt = (!rst || !imem_req || imem_valid) ? 0 : len_cnt + 1;

        if (sb_en && IF_valid && !last_stall) begin
            checks++;
            if (exp_deliv.size() == 0) begin
                errors++;
                $display("FAIL deliver: unexpected instr %h next %h", Instruction, Next_Address);
            end else begin
                a = exp_deliv.pop_front();
                if (Instruction !== mem_word(a) || Next_Address !== a + 32'd4) begin
                    errors++;
                    $display("FAIL deliver: got instr %h next %h, required %h next %h",
                             Instruction, Next_Address, mem_word(a), a + 32'd4);
                end
            end
            if (bub_chk && !first_deliv) begin
                checks++;
                if (bub_cnt != waits) begin
                    errors++;
                    $display("FAIL bubbles: got %0d, required %0d", bub_cnt, waits);
                end
            end
            first_deliv = 0;
            bub_cnt = 0;
        end else if (sb_en && !IF_valid) begin
            bub_cnt++;
        end
        last_stall = ~PCWrite | freeze;
    end

    typedef struct {
        logic        rst, pcw, frz, src, fl;
        logic [31:0] ba;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr, e_next;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic r, input logic pw, input logic fz, input logic s,
                                input logic f, input logic [31:0] ba, input logic rq,
                                input logic [31:0] ad, input logic v, input logic [31:0] ins,
                                input logic [31:0] nx);
        vec_t t;
        t.rst = r; t.pcw = pw; t.frz = fz; t.src = s; t.fl = f; t.ba = ba;
        t.e_req = rq; t.e_addr = ad; t.e_val = v; t.e_instr = ins; t.e_next = nx;
        return t;
    endfunction

    task automatic wait_sb_empty(input string name);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #1;
            if (exp_addr.size() == 0 && exp_deliv.size() == 0) done = 1;
        end
        sb_en = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d fetches and %0d deliveries outstanding, required 0",
                     name, exp_addr.size(), exp_deliv.size());
        end
    endtask

    task automatic do_reset(input int w);
        rst = 0; PCWrite = 1; freeze = 0; PCSrc = 0; flush = 0; Branch_Address = 0;
        waits = w;
        exp_addr.delete();
        exp_deliv.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Zero-wait cycle table: reset, stream, stall/release, flush, redirect.
        tbl[0]  = mk(0,1,0,0,0,0,         0,32'h00, 0,NOP,            32'h00);
        tbl[1]  = mk(0,1,0,0,0,0,         0,32'h00, 0,NOP,            32'h00);
        tbl[2]  = mk(1,1,0,0,0,0,         1,32'h00, 0,NOP,            32'h00);
        tbl[3]  = mk(1,1,0,0,0,0,         1,32'h04, 1,mem_word(32'h0),32'h04);
        tbl[4]  = mk(1,1,0,0,0,0,         1,32'h08, 1,mem_word(32'h4),32'h08);
        tbl[5]  = mk(1,1,0,0,0,0,         1,32'h0C, 1,mem_word(32'h8),32'h0C);
        tbl[6]  = mk(1,1,0,0,0,0,         1,32'h10, 1,mem_word(32'hC),32'h10);
        tbl[7]  = mk(1,0,1,0,0,0,         0,32'h10, 1,mem_word(32'hC),32'h10);
        tbl[8]  = mk(1,0,1,0,0,0,         0,32'h10, 1,mem_word(32'hC),32'h10);
        tbl[9]  = mk(1,0,1,0,0,0,         0,32'h10, 1,mem_word(32'hC),32'h10);
        tbl[10] = mk(1,1,0,0,0,0,         1,32'h14, 1,mem_word(32'h10),32'h14);
        tbl[11] = mk(1,1,0,0,0,0,         1,32'h18, 1,mem_word(32'h14),32'h18);
        tbl[12] = mk(1,1,0,0,1,0,         1,32'h1C, 0,NOP,            32'h18);
        tbl[13] = mk(1,1,0,0,0,0,         1,32'h20, 1,mem_word(32'h1C),32'h20);
        tbl[14] = mk(1,1,0,1,0,32'h103,   1,32'h100,0,NOP,            32'h20);
        tbl[15] = mk(1,1,0,0,0,0,         1,32'h104,1,mem_word(32'h100),32'h104);

        waits = 0;
        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; PCWrite = tbl[i].pcw; freeze = tbl[i].frz;
            PCSrc = tbl[i].src; flush = tbl[i].fl; Branch_Address = tbl[i].ba;
            @(posedge clk); #1;
            checks++;
            if (imem_req !== tbl[i].e_req || imem_addr !== tbl[i].e_addr ||
                IF_valid !== tbl[i].e_val || Instruction !== tbl[i].e_instr ||
                Next_Address !== tbl[i].e_next) begin
                errors++;
                $display("FAIL table[%0d]: req=%0b addr=%h val=%0b instr=%h next=%h, required req=%0b addr=%h val=%0b instr=%h next=%h",
                         i, imem_req, imem_addr, IF_valid, Instruction, Next_Address,
                         tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_instr, tbl[i].e_next);
            end
        end

        // Two-wait memory stream, then redirect while 0x20 is pending.
        do_reset(2);
        for (int a = 0; a <= 32'h20; a += 4) exp_addr.push_back(a);
        exp_addr.push_back(32'h100);
        exp_addr.push_back(32'h104);
        for (int a = 0; a < 32'h20; a += 4) exp_deliv.push_back(a);
        exp_deliv.push_back(32'h100);
        exp_deliv.push_back(32'h104);
        sb_en = 1; bub_chk = 1; first_deliv = 1; bub_cnt = 0;
        rst = 1;
        begin
            bit seen = 0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(posedge clk); #1;
                if (imem_req && imem_addr == 32'h20) seen = 1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL reach_0x20: request for 0x20 not seen, required within 200 cycles");
            end
        end
        bub_chk = 0;
        @(posedge clk); #1;
        PCSrc = 1; Branch_Address = 32'h100;
        @(posedge clk); #1;
        PCSrc = 0;
        checks++;
        if (!imem_req || imem_addr !== 32'h20 || IF_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_state: req=%0b addr=%h val=%0b, required req=1 addr=00000020 val=0",
                     imem_req, imem_addr, IF_valid);
        end
        wait_sb_empty("redirect_wait");

        // Redirect during a stall (HOLD) to the top word, then wrap to 0.
        do_reset(0);
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_deliv = '{32'h0, 32'h4, 32'hFFFF_FFFC, 32'h0, 32'h4};
        sb_en = 1; bub_chk = 0; first_deliv = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        PCWrite = 0; freeze = 1;
        @(posedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || Instruction !== mem_word(32'h4)) begin
            errors++;
            $display("FAIL hold_state: req=%0b instr=%h, required req=0 instr=%h",
                     imem_req, Instruction, mem_word(32'h4));
        end
        PCSrc = 1; Branch_Address = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        PCSrc = 0; PCWrite = 1; freeze = 0;
        checks++;
        if (!imem_req || imem_addr !== 32'hFFFF_FFFC || IF_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_redirect: req=%0b addr=%h val=%0b, required req=1 addr=fffffffc val=0",
                     imem_req, imem_addr, IF_valid);
        end
        wait_sb_empty("wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
